// File: rtl/lfsr_seq_checker.sv
// Receive-side checker for the 2-bit symbol stream of an 8-bit LFSR (x^8+x^4+x^3+x^2+1).
// Acquires the generator state from received symbols, then flywheels a local copy and counts mismatches.
module lfsr_seq_checker #(
  parameter int ERR_W       = 16,
  parameter int LOSS_THRESH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       in_sym,
  input  logic             clr_cnt,
  output logic             locked,
  output logic [1:0]       exp_sym,
  output logic             err_pulse,
  output logic             lost,
  output logic [ERR_W-1:0] err_count
);

  // Handshake: in_valid qualifies in_sym for exactly one cycle; there is no back-pressure.
  typedef enum logic {ACQ = 1'b0, LOCK = 1'b1} state_t;

  localparam int MISS_W = $clog2(LOSS_THRESH + 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_THRESH - 1);

  state_t             state, state_nx;
  logic [7:0]         r, r_nx, r_step;
  logic [2:0]         acq_cnt, acq_nx;
  logic [MISS_W-1:0]  miss_cnt, miss_nx;
  logic [1:0]         exp_nx;
  logic               err_nx, lost_nx;
  logic [ERR_W-1:0]   cnt_nx;

  function automatic logic fb(input logic [7:0] s);
    return s[7] ^ s[3] ^ s[2] ^ s[1];
  endfunction

  assign r_step = {r[6:0], fb(r)};
  assign locked = (state == LOCK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACQ;
      r         <= 8'h00;
      acq_cnt   <= 3'd0;
      miss_cnt  <= '0;
      exp_sym   <= 2'b00;
      err_pulse <= 1'b0;
      lost      <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nx;
      r         <= r_nx;
      acq_cnt   <= acq_nx;
      miss_cnt  <= miss_nx;
      exp_sym   <= exp_nx;
      err_pulse <= err_nx;
      lost      <= lost_nx;
      err_count <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    r_nx     = r;
    acq_nx   = acq_cnt;
    miss_nx  = miss_cnt;
    exp_nx   = exp_sym;
    err_nx   = 1'b0;
    lost_nx  = 1'b0;
    cnt_nx   = err_count;
    if (in_valid) begin
      case (state)
        ACQ: begin
          if (acq_cnt == 3'd0) begin
            r_nx   = {r[5:0], in_sym};
            acq_nx = 3'd1;
          end else if (in_sym[1] != r[0]) begin
            // First bit of a symbol must repeat the second bit of the previous one.
            r_nx   = {6'b0, in_sym};
            acq_nx = 3'd1;
          end else begin
            r_nx   = {r[6:0], in_sym[0]};
            acq_nx = acq_cnt + 3'd1;
            if (acq_cnt == 3'd6) begin
              acq_nx = 3'd0;
              if (r_nx != 8'h00) begin
                state_nx = LOCK;
                miss_nx  = '0;
                exp_nx   = {r_nx[0], fb(r_nx)};
              end
            end
          end
        end
        LOCK: begin
          r_nx   = r_step;
          exp_nx = {r_step[0], fb(r_step)};
          if (in_sym != exp_sym) begin
            err_nx = 1'b1;
            if (!(&err_count)) cnt_nx = err_count + ERR_W'(1);
            if (miss_cnt == MISS_LAST) begin
              lost_nx  = 1'b1;
              state_nx = ACQ;
              r_nx     = 8'h00;
              acq_nx   = 3'd0;
              miss_nx  = '0;
              exp_nx   = 2'b00;
            end else begin
              miss_nx = miss_cnt + MISS_W'(1);
            end
          end else begin
            miss_nx = '0;
          end
        end
        default: state_nx = ACQ;
      endcase
    end
    if (clr_cnt) cnt_nx = '0;
  end

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Bench for lfsr_seq_checker: a reference model fills an expected queue per driven cycle,
// DUT outputs are popped and compared one cycle later; a 2-bit-counter instance checks saturation.
module tb_lfsr_seq_checker;

  localparam int THRESH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [1:0]  in_sym = 2'b00;
  logic        clr_cnt = 1'b0;

  logic        locked, err_pulse, lost;
  logic [1:0]  exp_sym;
  logic [15:0] err_count;
  logic        locked2, err_pulse2, lost2;
  logic [1:0]  exp_sym2;
  logic [1:0]  err_count2;

  lfsr_seq_checker #(.ERR_W(16), .LOSS_THRESH(THRESH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sym(in_sym), .clr_cnt(clr_cnt),
    .locked(locked), .exp_sym(exp_sym), .err_pulse(err_pulse), .lost(lost),
    .err_count(err_count)
  );

  lfsr_seq_checker #(.ERR_W(2), .LOSS_THRESH(THRESH)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sym(in_sym), .clr_cnt(clr_cnt),
    .locked(locked2), .exp_sym(exp_sym2), .err_pulse(err_pulse2), .lost(lost2),
    .err_count(err_count2)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard state
  int n_checks = 0;
  int n_pass   = 0;
  logic [22:0] exp_q[$];

  // Reference model state
  logic        m_lock;
  logic [7:0]  m_r;
  int          m_acq, m_miss;
  logic        m_err, m_lost;
  logic [15:0] m_cnt;
  logic [1:0]  m_cnt2;

  // Generator
  logic [7:0]  g;

  function automatic logic fbm(input logic [7:0] s);
    return s[7] ^ s[3] ^ s[2] ^ s[1];
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], fbm(s)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic model_cycle(input logic v, input logic [1:0] sym, input logic clr, input logic r_in);
    logic [1:0] e;
    if (r_in) begin
      m_lock = 0; m_r = 8'h00; m_acq = 0; m_miss = 0;
      m_err = 0; m_lost = 0; m_cnt = 0; m_cnt2 = 0;
      return;
    end
    m_err = 0;
    m_lost = 0;
    if (v) begin
      if (!m_lock) begin
        if (m_acq == 0) begin
          m_r = {m_r[5:0], sym}; m_acq = 1;
        end else if (sym[1] != m_r[0]) begin
          m_r = {6'b0, sym}; m_acq = 1;
        end else begin
          m_r = {m_r[6:0], sym[0]}; m_acq++;
        end
        if (m_acq == 7) begin
          m_acq = 0;
          if (m_r != 8'h00) begin m_lock = 1; m_miss = 0; end
        end
      end else begin
        e = {m_r[0], fbm(m_r)};
        m_r = lfsr_step(m_r);
        if (sym != e) begin
          m_err = 1;
          if (m_cnt != 16'hFFFF) m_cnt++;
          if (m_cnt2 != 2'b11) m_cnt2++;
          m_miss++;
          if (m_miss == THRESH) begin
            m_lost = 1; m_lock = 0; m_acq = 0; m_r = 8'h00; m_miss = 0;
          end
        end else begin
          m_miss = 0;
        end
      end
    end
    if (clr) begin m_cnt = 0; m_cnt2 = 0; end
  endtask

  // Driver: one clock cycle of stimulus, expected outputs queued, DUT outputs compared after the edge
  task automatic step(input logic v, input logic [1:0] sym, input logic clr, input logic r_in);
    logic [22:0] e;
    logic [1:0]  esym;
    rst = r_in; in_valid = v; in_sym = sym; clr_cnt = clr;
    model_cycle(v, sym, clr, r_in);
    esym = m_lock ? {m_r[0], fbm(m_r)} : 2'b00;
    exp_q.push_back({m_lock, esym, m_err, m_lost, m_cnt, m_cnt2});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("locked", locked, e[22]);
    if (e[22]) check("exp_sym", exp_sym, e[21:20]);
    check("err_pulse", err_pulse, e[19]);
    check("lost", lost, e[18]);
    check("err_count", err_count, e[17:2]);
    check("w2_locked", locked2, e[22]);
    if (e[22]) check("w2_exp_sym", exp_sym2, e[21:20]);
    check("w2_err_pulse", err_pulse2, e[19]);
    check("w2_lost", lost2, e[18]);
    check("w2_err_count", err_count2, e[1:0]);
  endtask

  task automatic send_gen(input logic [1:0] flip, input logic clr);
    logic [1:0] s;
    s = g[7:6] ^ flip;
    g = lfsr_step(g);
    step(1'b1, s, clr, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'(($urandom_range(0, 3))), 1'b0, 1'b0);
  endtask

  initial begin
    int pulses;
    // Reset
    step(1'b0, 2'b00, 1'b0, 1'b1);
    step(1'b1, 2'b11, 1'b1, 1'b1);
    check("rst_locked", locked, 0);
    check("rst_exp_sym", exp_sym, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_lost", lost, 0);
    check("rst_err_count", err_count, 0);

    // 1: acquire from seed 8'hBD, then clean running
    g = 8'hBD;
    for (int i = 0; i < 6; i++) send_gen(2'b00, 1'b0);
    check("t1_locked_early", locked, 0);
    send_gen(2'b00, 1'b0);
    check("t1_locked", locked, 1);
    check("t1_exp_sym_gen", exp_sym, g[7:6]);
    check("t1_exp_sym_val", exp_sym, 2'b11);
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      send_gen(2'b00, 1'b0);
      if (err_pulse || lost) pulses++;
    end
    check("t1_pulses", pulses, 0);
    check("t1_err_count", err_count, 0);

    // 2: single flipped symbol
    send_gen(2'b10, 1'b0);
    check("t2_err_pulse", err_pulse, 1);
    check("t2_err_count", err_count, 1);
    check("t2_locked", locked, 1);
    for (int i = 0; i < 20; i++) send_gen(2'b00, 1'b0);
    check("t2_err_count_after", err_count, 1);

    // 3: four consecutive corrupted symbols force loss, then reacquire
    step(1'b0, 2'b00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) send_gen(2'b11, 1'b0);
    check("t3_locked_3err", locked, 1);
    check("t3_lost_3err", lost, 0);
    send_gen(2'b11, 1'b0);
    check("t3_lost", lost, 1);
    check("t3_locked", locked, 0);
    check("t3_err_count", err_count, 4);
    for (int i = 0; i < 7; i++) send_gen(2'b00, 1'b0);
    check("t3_relocked", locked, 1);
    check("t3_err_count_kept", err_count, 4);

    // 4: random valid gaps with sparse injected errors
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) < 30) begin
        step(1'b0, 2'(($urandom_range(0, 3))), 1'b0, 1'b0);
        check("t4_pulse_after_gap", err_pulse, 0);
      end else if ($urandom_range(0, 99) < 3) begin
        send_gen(2'b11, 1'b0);
      end else begin
        send_gen(2'b00, 1'b0);
      end
    end
    idle(3);

    // 5: all-zero stream never locks; overlap violation restarts acquisition
    step(1'b0, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 30; i++) step(1'b1, 2'b00, 1'b0, 1'b0);
    check("t5_zero_nolock", locked, 0);
    step(1'b0, 2'b00, 1'b0, 1'b1);
    step(1'b1, 2'b10, 1'b0, 1'b0);
    g = 8'hED;
    for (int i = 0; i < 6; i++) send_gen(2'b00, 1'b0);
    check("t5_restart_nolock", locked, 0);
    send_gen(2'b00, 1'b0);
    check("t5_restart_lock", locked, 1);
    check("t5_exp_sym_gen", exp_sym, g[7:6]);

    // 6: reset mid-lock, clear vs increment, narrow counter saturation
    send_gen(2'b01, 1'b0);
    send_gen(2'b00, 1'b0);
    send_gen(2'b01, 1'b0);
    check("t6_pre_rst_count", err_count, 2);
    step(1'b1, g[7:6], 1'b0, 1'b1);
    check("t6_rst_locked", locked, 0);
    check("t6_rst_err_count", err_count, 0);
    for (int i = 0; i < 7; i++) send_gen(2'b00, 1'b0);
    check("t6_relock", locked, 1);
    send_gen(2'b11, 1'b1);
    check("t6_clr_err_count", err_count, 0);
    check("t6_clr_err_pulse", err_pulse, 1);
    for (int i = 0; i < 5; i++) begin
      send_gen(2'b10, 1'b0);
      send_gen(2'b00, 1'b0);
    end
    check("t6_err_count_16", err_count, 5);
    check("t6_err_count_sat", err_count2, 2'b11);
    check("t6_still_locked", locked, 1);
    idle(2);

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
